mux_sel_sequencer: RTL and testbench
====================================

MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter: DWELL, 1, clock cycles each select value is held; legal range 1..16.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: load_valid  input  1  request to load a new 8-bit word.
REQ-006 Port: load_data  input  8  word to be scanned.
REQ-007 Port: load_ready  output  1  word accepted when load_valid && load_ready at a rising edge.
REQ-008 Port: abort  input  1  cancel the current scan.
REQ-009 Port: I  output  8  registered word driven to the mux8_1 data inputs.
REQ-010 Port: S  output  3  registered select driven to the mux8_1 select.
REQ-011 Port: sel_valid  output  1  S is in an active scan and the mux output Y is meaningful.
REQ-012 Port: last  output  1  final cycle of the final select value.
REQ-013 Port: done  output  1  one-cycle pulse after a scan completes normally.

Function
REQ-014 The state machine SHALL have three states: IDLE, SCAN and DONE; all outputs except load_ready and last SHALL be registered.
REQ-015 load_ready SHALL equal (state==IDLE) && !abort; load_valid outside IDLE SHALL be ignored, with no queuing.
REQ-016 On acceptance in IDLE, the block SHALL capture I<=load_data, S<=0 and dwell_cnt<=0, and enter SCAN; sel_valid=1 and S=0 SHALL be visible in the following cycle (1-cycle latency).
REQ-017 In SCAN, dwell_cnt SHALL increment every cycle; when dwell_cnt==DWELL-1 and S!=7, S<=S+1 and dwell_cnt<=0.
REQ-018 In SCAN, when dwell_cnt==DWELL-1 and S==7, the next state SHALL be DONE; S SHALL never wrap from 7 to 0 within a scan.
REQ-019 A scan SHALL occupy exactly 8*DWELL cycles with sel_valid=1, and S SHALL take the values 0..7 in ascending order, each for DWELL cycles.
REQ-020 last SHALL be combinational: (state==SCAN) && S==7 && dwell_cnt==DWELL-1.
REQ-021 DONE SHALL last one cycle with done=1, sel_valid=0, S=7 and I held, then return to IDLE.
REQ-022 I SHALL remain stable from load until the next accepted load, including through DONE, IDLE and abort.
REQ-023 abort in SCAN or DONE SHALL force IDLE at the next edge, with S<=0, sel_valid<=0, dwell_cnt<=0 and no done pulse; I is retained.
REQ-024 abort in IDLE SHALL block a same-cycle load (load_ready=0) and have no other effect.
REQ-025 abort coinciding with last SHALL take priority: the next state is IDLE and done SHALL NOT pulse.
REQ-026 With DWELL=1, S SHALL change every cycle and last SHALL coincide with the single S=7 cycle.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL set state=IDLE, I=8'h00, S=3'b000, dwell_cnt=0, sel_valid=0 and done=0; load_ready SHALL read 1 after reset when abort=0.
REQ-028 rst SHALL override abort and load_valid in the same cycle; rst mid-scan SHALL terminate the scan without a done pulse.

Verification
REQ-029 DWELL=1: load 8'b11110110 at cycle 0 -> S=0..7 on cycles 1..8 with sel_valid=1, mux Y sequence 0,1,1,0,1,1,1,1, last=1 at cycle 8, done=1 at cycle 9, load_ready=1 at cycle 10.
REQ-030 DWELL=4: load 8'hA5 -> each S value is held 4 cycles, sel_valid is high for 32 cycles, done pulses once, and I=8'hA5 throughout.
REQ-031 load_valid=1 held continuously with data changing every cycle during SCAN -> only the word presented at the IDLE acceptance is captured; the next word is accepted on the first IDLE cycle after DONE.
REQ-032 abort asserted at S=3 -> next cycle IDLE with S=0 and sel_valid=0, no done pulse, and I unchanged; abort together with load_valid in IDLE -> no load.
REQ-033 abort coincident with last -> no done pulse and return to IDLE; rst asserted at S=5 -> all outputs take their reset values at the next edge.
REQ-034 Post-reset checks -> I=0, S=0, sel_valid=0, done=0 and load_ready=1 before any stimulus.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
//   Scans an 8-bit word through an external mux8_1. After a word is
//   accepted, the select S steps 0..7 in ascending order and holds each
//   value for DWELL cycles. A one-cycle done pulse follows a scan that
//   completes normally.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for load_valid; load_ready = !abort
//   SCAN  | stepping S through 0..7, sel_valid = 1
//   DONE  | single cycle, done = 1, S = 7, then back to IDLE
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   load_valid  request to load a new word
//   load_data   word to be scanned
//   load_ready  word accepted when load_valid && load_ready (combinational)
//   abort       cancel the current scan; blocks a load while in IDLE
//   I           registered word driven to the mux data inputs
//   S           registered mux select
//   sel_valid   S belongs to an active scan
//   last        final cycle of S = 7 (combinational)
//   done        one-cycle pulse after a normal scan completion
module mux_sel_sequencer #(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic       abort,
    output logic [7:0] I,
    output logic [2:0] S,
    output logic       sel_valid,
    output logic       last,
    output logic       done
);

    // DWELL is limited to 1..16, so a 4-bit counter covers 0..DWELL-1.
    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] dwell_cnt;
    logic [3:0] dwell_cnt_next;
    logic [7:0] i_next;
    logic [2:0] s_next;
    logic       sel_valid_next;
    logic       done_next;
    logic       dwell_end;

    assign dwell_end  = (dwell_cnt == DWELL_LAST);
    assign load_ready = (state == IDLE) && !abort;
    assign last       = (state == SCAN) && (S == 3'd7) && dwell_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            I         <= 8'h00;
            S         <= 3'd0;
            dwell_cnt <= 4'd0;
            sel_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            I         <= i_next;
            S         <= s_next;
            dwell_cnt <= dwell_cnt_next;
            sel_valid <= sel_valid_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        i_next         = I;
        s_next         = S;
        dwell_cnt_next = dwell_cnt;
        sel_valid_next = 1'b0;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (load_valid && load_ready) begin
                    i_next         = load_data;
                    s_next         = 3'd0;
                    dwell_cnt_next = 4'd0;
                    sel_valid_next = 1'b1;
                    state_next     = SCAN;
                end
            end
            SCAN: begin
                // abort wins over the final-cycle transition into DONE
                if (abort) begin
                    state_next     = IDLE;
                    s_next         = 3'd0;
                    dwell_cnt_next = 4'd0;
                end else if (dwell_end) begin
                    dwell_cnt_next = 4'd0;
                    if (S == 3'd7) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        s_next         = S + 3'd1;
                        sel_valid_next = 1'b1;
                    end
                end else begin
                    dwell_cnt_next = dwell_cnt + 4'd1;
                    sel_valid_next = 1'b1;
                end
            end
            DONE: begin
                state_next     = IDLE;
                s_next         = 3'd0;
                dwell_cnt_next = 4'd0;
            end
            default: begin
                state_next     = IDLE;
                s_next         = 3'd0;
                dwell_cnt_next = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Testbench for mux_sel_sequencer. Two instances (DWELL=1 and DWELL=4)
// share one stimulus stream; each is compared every cycle against a
// scan-position model (elapsed cycles since load, S = k / DWELL).
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic       abort;
    logic [7:0] load_data;

    logic       lr_a, sv_a, last_a, done_a;
    logic [7:0] i_a;
    logic [2:0] s_a;
    logic       lr_b, sv_b, last_b, done_b;
    logic [7:0] i_b;
    logic [2:0] s_b;

    always #5 clk = ~clk;

    mux_sel_sequencer #(.DWELL(1)) u_dut_d1 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (lr_a),
        .abort      (abort),
        .I          (i_a),
        .S          (s_a),
        .sel_valid  (sv_a),
        .last       (last_a),
        .done       (done_a)
    );

    mux_sel_sequencer #(.DWELL(4)) u_dut_d4 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (lr_b),
        .abort      (abort),
        .I          (i_b),
        .S          (s_b),
        .sel_valid  (sv_b),
        .last       (last_b),
        .done       (done_b)
    );

    // reference model, index 0 -> DWELL=1, index 1 -> DWELL=4
    int         m_dw [2] = '{1, 4};
    bit         m_act [2];
    bit         m_done [2];
    bit         m_szero [2];
    int         m_k [2];
    logic [7:0] m_word [2];
    int         sv_run [2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset(input int n);
        m_act[n]   = 1'b0;
        m_done[n]  = 1'b0;
        m_szero[n] = 1'b1;
        m_k[n]     = 0;
        m_word[n]  = 8'h00;
    endtask

    task automatic model_step(input int n);
        if (rst) begin
            model_reset(n);
        end else if (m_act[n]) begin
            if (abort) begin
                m_act[n]   = 1'b0;
                m_szero[n] = 1'b1;
            end else if (m_k[n] == 8 * m_dw[n] - 1) begin
                m_act[n]  = 1'b0;
                m_done[n] = 1'b1;
            end else begin
                m_k[n]++;
            end
        end else if (m_done[n]) begin
            m_done[n]  = 1'b0;
            m_szero[n] = abort;
        end else if (load_valid && !abort) begin
            m_act[n]  = 1'b1;
            m_k[n]    = 0;
            m_word[n] = load_data;
        end
    endtask

    task automatic check_inst(input int n, input logic lr, input logic sv, input logic lst,
                              input logic dn, input logic [7:0] iv, input logic [2:0] sel);
        string p;
        int    pos;
        p = (n == 0) ? "d1" : "d4";
        chk({p, "_sel_valid"}, sv, m_act[n]);
        chk({p, "_last"}, lst, m_act[n] && (m_k[n] == 8 * m_dw[n] - 1));
        chk({p, "_done"}, dn, m_done[n]);
        chk({p, "_load_ready"}, lr, !m_act[n] && !m_done[n] && !abort);
        chk({p, "_I"}, iv, m_word[n]);
        if (m_act[n]) begin
            pos = m_k[n] / m_dw[n];
            chk({p, "_S"}, sel, pos);
            chk({p, "_Y"}, iv[sel], m_word[n][pos]);
        end else if (m_done[n]) begin
            chk({p, "_S_done"}, sel, 7);
        end else if (m_szero[n]) begin
            chk({p, "_S_idle"}, sel, 0);
        end
        if (sv) sv_run[n]++;
        if (dn) begin
            chk({p, "_scan_len"}, sv_run[n], 8 * m_dw[n]);
            sv_run[n] = 0;
        end else if (!m_act[n]) begin
            sv_run[n] = 0;
        end
    endtask

    task automatic cycle(input logic r, input logic lv, input logic ab, input logic [7:0] d);
        @(negedge clk);
        rst        = r;
        load_valid = lv;
        abort      = ab;
        load_data  = d;
        #1;
        check_inst(0, lr_a, sv_a, last_a, done_a, i_a, s_a);
        check_inst(1, lr_b, sv_b, last_b, done_b, i_b, s_b);
        @(posedge clk);
        #1;
        model_step(0);
        model_step(1);
    endtask

    // idles until the DWELL=4 instance reaches scan position tgt_k
    task automatic run_until_b(input int tgt_k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (m_act[1] && m_k[1] == tgt_k) begin
                ok = 1'b1;
                return;
            end
            cycle(1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    initial begin
        bit ok;
        rst        = 1'b1;
        load_valid = 1'b0;
        abort      = 1'b0;
        load_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        model_reset(0);
        model_reset(1);
        sv_run[0] = 0;
        sv_run[1] = 0;

        // post-reset idle
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // basic scan of 8'b11110110 on both dwell settings
        cycle(1'b0, 1'b1, 1'b0, 8'b1111_0110);
        repeat (40) cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // load_valid held with changing data: only IDLE acceptances capture
        repeat (45) cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
        repeat (40) cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // abort at S=3, then abort together with a load in IDLE
        cycle(1'b0, 1'b1, 1'b0, 8'hA5);
        run_until_b(3 * 4, ok);
        chk("reach_s3", ok, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'h3C);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // abort coincident with last
        cycle(1'b0, 1'b1, 1'b0, 8'h5A);
        run_until_b(31, ok);
        chk("reach_last", ok, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // reset at S=5 overriding abort and load
        cycle(1'b0, 1'b1, 1'b0, 8'hC3);
        run_until_b(5 * 4, ok);
        chk("reach_s5", ok, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 8'hFF);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 250) == 0, ($urandom % 3) != 0,
                  ($urandom % 25) == 0, 8'($urandom));
        end
        repeat (40) cycle(1'b0, 1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
